// File: rtl/uc_seq.sv
// uc_seq: control unit for the micro-core.
// Combinational decode in RUN, plus a RUN/HALT FSM with a sticky illegal flag and a retire counter.
module uc_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        z,
   output logic        s_inc,
   output logic        s_abs,
   output logic        s_inm,
   output logic        we3,
   output logic        wez,
   output logic [2:0]  op,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] icount
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        illegal_q, illegal_d;
   logic [15:0] icount_q, icount_d;

   logic [3:0]  dec;
   logic        jmp, stop, bad;
   logic        unused_lo;

   assign dec       = opcode[5:2];
   assign unused_lo = ^opcode[1:0];

   always_comb begin
      s_inc = 1'b1;
      s_abs = 1'b0;
      s_inm = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
      op    = 3'b000;
      jmp   = 1'b0;
      stop  = 1'b0;
      bad   = 1'b0;
      if (!reset) begin
         jmp = 1'b0;
      end else if (state_q == HALT) begin
         jmp = 1'b1;
      end else begin
         unique case (1'b1)
            dec[3]: begin
               op  = dec[2:0];
               we3 = 1'b1;
               wez = 1'b1;
            end
            (dec == 4'b0000): begin
               s_inm = 1'b1;
               we3   = 1'b1;
            end
            (dec == 4'b0001): jmp = 1'b1;
            (dec == 4'b0010): jmp = z;
            (dec == 4'b0011): jmp = ~z;
            (dec == 4'b0100): s_inc = 1'b0;
            (dec == 4'b0101): begin
               jmp  = 1'b1;
               stop = 1'b1;
            end
            default: begin
               jmp = 1'b1;
               bad = 1'b1;
            end
         endcase
      end
      // Jump to the absolute field; HALT and illegal spin on their own address.
      if (jmp) begin
         s_inc = 1'b0;
         s_abs = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      icount_d  = icount_q;
      if (state_q == RUN) begin
         if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
         if (stop || bad) state_d = HALT;
         if (bad) illegal_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         illegal_q <= 1'b0;
         icount_q  <= 16'd0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         icount_q  <= icount_d;
      end
   end

   assign halted  = (state_q == HALT);
   assign illegal = illegal_q;
   assign icount  = icount_q;

endmodule
